// File: rtl/stream_stats_pkg.sv
// Shared definitions for the AXI-Stream statistics monitor and its
// AXI-Lite register block: hash parameters, register map, skid states.
package stream_stats_pkg;

  localparam logic [31:0] HASH_SEED_DEFAULT = 32'h811C9DC5;
  localparam int          HASH_ROT          = 5;

  // Read-only register map shared with the AXI-Lite register block
  localparam logic [3:0] REG_LAST_HASH  = 4'h0;
  localparam logic [3:0] REG_WORD_COUNT = 4'h4;
  localparam logic [3:0] REG_PKT_COUNT  = 4'h8;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_FULL  = 2'd2
  } skid_state_t;

  // Rolling hash: rotate left by HASH_ROT, then fold in the beat data
  function automatic logic [31:0] hash_step(input logic [31:0] h, input logic [31:0] d);
    return {h[31-HASH_ROT:0], h[31:32-HASH_ROT]} ^ d;
  endfunction

endpackage

// File: rtl/axis_stream_stats_if.sv
// AXI-Stream channel bundle (32-bit data + last) used on both sides
// of the statistics monitor.
interface axis_stream_stats_if;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tready;
  logic        tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_skid_buffer.sv
// Two-entry registered skid buffer: output register plus one skid
// register, with a registered upstream ready that drops only when full.
module axis_skid_buffer
  import stream_stats_pkg::*;
#(
  parameter int WIDTH = 33
) (
  input  logic             ACLK,
  input  logic             ARESETN,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready
);

  skid_state_t      state_reg, state_next;
  logic [WIDTH-1:0] out_data_reg, out_data_next;
  logic [WIDTH-1:0] skid_data_reg, skid_data_next;
  logic             s_ready_reg, s_ready_next;
  logic             accept;
  logic             m_hs;

  assign accept  = s_valid && s_ready_reg;
  assign m_hs    = (state_reg != SKID_EMPTY) && m_ready;
  assign s_ready = s_ready_reg;
  assign m_valid = (state_reg != SKID_EMPTY);
  assign m_data  = out_data_reg;

  // State, payload and ready registers; reset empties both entries
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state_reg     <= SKID_EMPTY;
      out_data_reg  <= '0;
      skid_data_reg <= '0;
      s_ready_reg   <= 1'b1;
    end else begin
      state_reg     <= state_next;
      out_data_reg  <= out_data_next;
      skid_data_reg <= skid_data_next;
      s_ready_reg   <= s_ready_next;
    end
  end

  // Next-state and payload steering; ready is precomputed from next state
  always_comb begin
    state_next     = state_reg;
    out_data_next  = out_data_reg;
    skid_data_next = skid_data_reg;
    unique case (state_reg)
      SKID_EMPTY: begin
        if (accept) begin
          out_data_next = s_data;
          state_next    = SKID_ONE;
        end
      end
      SKID_ONE: begin
        if (accept && m_hs) begin
          out_data_next = s_data;
        end else if (accept) begin
          skid_data_next = s_data;
          state_next     = SKID_FULL;
        end else if (m_hs) begin
          state_next = SKID_EMPTY;
        end
      end
      SKID_FULL: begin
        if (m_hs) begin
          out_data_next = skid_data_reg;
          state_next    = SKID_ONE;
        end
      end
      default: state_next = SKID_EMPTY;
    endcase
    s_ready_next = (state_next != SKID_FULL);
  end

endmodule

// File: rtl/axis_stream_stats.sv
// Pass-through AXI-Stream monitor: forwards beats through a skid buffer
// and keeps word/packet counters plus a rolling per-packet hash.
module axis_stream_stats
  import stream_stats_pkg::*;
#(
  parameter logic [31:0] HASH_SEED = HASH_SEED_DEFAULT
) (
  input  logic                      ACLK,
  input  logic                      ARESETN,
  axis_stream_stats_if.slave        s_axis,
  axis_stream_stats_if.master       m_axis,
  input  logic                      stat_clear,
  output logic [31:0]               ro_last_hash,
  output logic [31:0]               ro_word_count,
  output logic [31:0]               ro_pkt_count,
  output logic                      in_packet
);

  logic [32:0] m_payload;
  logic        accept;
  logic [31:0] hash_next;
  logic [31:0] acc_reg;
  logic [31:0] last_hash_reg;
  logic [31:0] word_count_reg;
  logic [31:0] pkt_count_reg;
  logic        in_packet_reg;

  axis_skid_buffer #(.WIDTH(33)) u_skid (
    .ACLK    (ACLK),
    .ARESETN (ARESETN),
    .s_data  ({s_axis.tlast, s_axis.tdata}),
    .s_valid (s_axis.tvalid),
    .s_ready (s_axis.tready),
    .m_data  (m_payload),
    .m_valid (m_axis.tvalid),
    .m_ready (m_axis.tready)
  );

  assign m_axis.tdata = m_payload[31:0];
  assign m_axis.tlast = m_payload[32];

  assign accept    = s_axis.tvalid && s_axis.tready;
  assign hash_next = hash_step(acc_reg, s_axis.tdata);

  // Statistics on the upstream side; clear wins over a same-cycle beat
  // for the visible registers but never disturbs the running hash
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      acc_reg        <= HASH_SEED;
      in_packet_reg  <= 1'b0;
      last_hash_reg  <= '0;
      word_count_reg <= '0;
      pkt_count_reg  <= '0;
    end else begin
      if (accept) begin
        acc_reg       <= s_axis.tlast ? HASH_SEED : hash_next;
        in_packet_reg <= !s_axis.tlast;
      end
      if (stat_clear) begin
        last_hash_reg  <= '0;
        word_count_reg <= '0;
        pkt_count_reg  <= '0;
      end else if (accept) begin
        word_count_reg <= word_count_reg + 32'd1;
        if (s_axis.tlast) begin
          pkt_count_reg <= pkt_count_reg + 32'd1;
          last_hash_reg <= hash_next;
        end
      end
    end
  end

  assign ro_last_hash  = last_hash_reg;
  assign ro_word_count = word_count_reg;
  assign ro_pkt_count  = pkt_count_reg;
  assign in_packet     = in_packet_reg;

endmodule

// File: tb/tb_axis_stream_stats.sv
// Directed self-checking bench for axis_stream_stats: one instance with
// the default seed, one with seed 0 for hand-checkable hash values.
module tb_axis_stream_stats;

  logic ACLK = 1'b0;
  logic ARESETN;
  logic a_clear, b_clear;
  logic [31:0] a_hash, a_words, a_pkts, b_hash, b_words, b_pkts;
  logic a_inpkt, b_inpkt;
  int total = 0;
  int bad = 0;

  axis_stream_stats_if a_s();
  axis_stream_stats_if a_m();
  axis_stream_stats_if b_s();
  axis_stream_stats_if b_m();

  always #5 ACLK = ~ACLK;

  axis_stream_stats dut_a (
    .ACLK(ACLK), .ARESETN(ARESETN), .s_axis(a_s), .m_axis(a_m),
    .stat_clear(a_clear), .ro_last_hash(a_hash), .ro_word_count(a_words),
    .ro_pkt_count(a_pkts), .in_packet(a_inpkt)
  );

  axis_stream_stats #(.HASH_SEED(32'h0)) dut_b (
    .ACLK(ACLK), .ARESETN(ARESETN), .s_axis(b_s), .m_axis(b_m),
    .stat_clear(b_clear), .ro_last_hash(b_hash), .ro_word_count(b_words),
    .ro_pkt_count(b_pkts), .in_packet(b_inpkt)
  );

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic test_reset();
    ARESETN = 1'b0;
    repeat (3) tick();
    total++; if (a_s.tready !== 1'b1) begin bad++; $display("FAIL reset_tready: got %b want 1", a_s.tready); end
    total++; if (a_m.tvalid !== 1'b0) begin bad++; $display("FAIL reset_mvalid: got %b want 0", a_m.tvalid); end
    total++; if (a_m.tdata !== 32'h0) begin bad++; $display("FAIL reset_mdata: got %h want 0", a_m.tdata); end
    total++; if ({a_hash, a_words, a_pkts} !== 96'h0) begin bad++; $display("FAIL reset_ro: got %h %h %h want 0", a_hash, a_words, a_pkts); end
    total++; if (a_inpkt !== 1'b0) begin bad++; $display("FAIL reset_inpkt: got %b want 0", a_inpkt); end
    total++; if (b_s.tready !== 1'b1) begin bad++; $display("FAIL reset_tready_b: got %b want 1", b_s.tready); end
    ARESETN = 1'b1;
    $display("reset released");
  endtask

  task automatic test_single_beat();
    a_m.tready = 1'b1;
    a_s.tvalid = 1'b1; a_s.tdata = 32'h1; a_s.tlast = 1'b1;
    tick();
    a_s.tvalid = 1'b0;
    $display("single beat in data=00000001 last=1");
    total++; if (a_hash !== 32'h2393B8B1) begin bad++; $display("FAIL single_hash: got %h want 2393b8b1", a_hash); end
    total++; if (a_pkts !== 32'd1) begin bad++; $display("FAIL single_pkts: got %0d want 1", a_pkts); end
    total++; if (a_words !== 32'd1) begin bad++; $display("FAIL single_words: got %0d want 1", a_words); end
    total++; if (a_inpkt !== 1'b0) begin bad++; $display("FAIL single_inpkt: got %b want 0", a_inpkt); end
    total++; if ({a_m.tvalid, a_m.tlast, a_m.tdata} !== {2'b11, 32'h1}) begin bad++; $display("FAIL single_mout: got v=%b l=%b d=%h want v=1 l=1 d=00000001", a_m.tvalid, a_m.tlast, a_m.tdata); end
    tick();
    total++; if (a_m.tvalid !== 1'b0) begin bad++; $display("FAIL single_drain: got %b want 0", a_m.tvalid); end
  endtask

  task automatic test_back_pressure();
    logic [31:0] bp_data [0:2];
    logic        bp_last [0:2];
    logic [39:0] pat;
    int in_idx, out_idx, occ;
    logic s_acc, m_hs, m_l;
    logic [31:0] m_d;
    bp_data[0] = 32'h1; bp_last[0] = 1'b0;
    bp_data[1] = 32'h2; bp_last[1] = 1'b1;
    bp_data[2] = 32'h3; bp_last[2] = 1'b1;
    pat = {30'h3FFFFFFF, 10'b1110110100};
    in_idx = 0; out_idx = 0; occ = 0;
    for (int c = 0; c < 40 && out_idx < 3; c++) begin
      b_m.tready = pat[c];
      if (in_idx < 3) begin
        b_s.tvalid = 1'b1; b_s.tdata = bp_data[in_idx]; b_s.tlast = bp_last[in_idx];
      end else begin
        b_s.tvalid = 1'b0;
      end
      #3;
      total++; if (b_s.tready !== (occ != 2)) begin bad++; $display("FAIL bp_tready c=%0d: got %b want %b", c, b_s.tready, occ != 2); end
      total++; if (b_m.tvalid !== (occ != 0)) begin bad++; $display("FAIL bp_mvalid c=%0d: got %b want %b", c, b_m.tvalid, occ != 0); end
      s_acc = b_s.tvalid && b_s.tready;
      m_hs  = b_m.tvalid && b_m.tready;
      m_d = b_m.tdata; m_l = b_m.tlast;
      tick();
      if (m_hs) begin
        $display("bp out data=%h last=%b", m_d, m_l);
        total++; if ({m_l, m_d} !== {bp_last[out_idx], bp_data[out_idx]}) begin bad++; $display("FAIL bp_order %0d: got %b/%h want %b/%h", out_idx, m_l, m_d, bp_last[out_idx], bp_data[out_idx]); end
        out_idx++; occ--;
      end
      if (s_acc) begin
        if (in_idx == 1) begin
          total++; if (b_hash !== 32'h22) begin bad++; $display("FAIL bp_hash1: got %h want 00000022", b_hash); end
          total++; if (b_pkts !== 32'd1) begin bad++; $display("FAIL bp_pkts1: got %0d want 1", b_pkts); end
        end
        if (in_idx == 2) begin
          total++; if (b_hash !== 32'h3) begin bad++; $display("FAIL bp_hash2: got %h want 00000003", b_hash); end
          total++; if (b_words !== 32'd3) begin bad++; $display("FAIL bp_words2: got %0d want 3", b_words); end
          total++; if (b_pkts !== 32'd2) begin bad++; $display("FAIL bp_pkts2: got %0d want 2", b_pkts); end
        end
        in_idx++; occ++;
      end
    end
    b_s.tvalid = 1'b0;
    total++; if (out_idx !== 3) begin bad++; $display("FAIL bp_timeout: got %0d beats want 3", out_idx); end
  endtask

  task automatic test_clear_collision();
    b_m.tready = 1'b1;
    repeat (2) tick();
    b_s.tvalid = 1'b1; b_s.tdata = 32'h7; b_s.tlast = 1'b1; b_clear = 1'b1;
    tick();
    $display("clear with beat data=00000007 last=1");
    total++; if ({b_hash, b_words, b_pkts} !== 96'h0) begin bad++; $display("FAIL clr_zero: got %h %h %h want 0", b_hash, b_words, b_pkts); end
    b_clear = 1'b0; b_s.tdata = 32'h5;
    tick();
    b_s.tvalid = 1'b0;
    $display("beat data=00000005 last=1");
    total++; if (b_hash !== 32'h5) begin bad++; $display("FAIL clr_hash: got %h want 00000005", b_hash); end
    total++; if (b_pkts !== 32'd1) begin bad++; $display("FAIL clr_pkts: got %0d want 1", b_pkts); end
    total++; if (b_words !== 32'd1) begin bad++; $display("FAIL clr_words: got %0d want 1", b_words); end
  endtask

  task automatic test_word_wrap();
    a_m.tready = 1'b1;
    force dut_a.word_count_reg = 32'hFFFFFFFF;
    #1;
    release dut_a.word_count_reg;
    #1;
    total++; if (a_words !== 32'hFFFFFFFF) begin bad++; $display("FAIL wrap_preset: got %h want ffffffff", a_words); end
    a_s.tvalid = 1'b1; a_s.tdata = 32'hAA; a_s.tlast = 1'b0;
    tick();
    $display("wrap beat data=000000aa last=0");
    total++; if (a_words !== 32'h0) begin bad++; $display("FAIL wrap_words: got %h want 00000000", a_words); end
    total++; if (a_pkts !== 32'd1) begin bad++; $display("FAIL wrap_pkts: got %0d want 1", a_pkts); end
    total++; if (a_inpkt !== 1'b1) begin bad++; $display("FAIL wrap_inpkt: got %b want 1", a_inpkt); end
    a_s.tdata = 32'hBB; a_s.tlast = 1'b1;
    tick();
    a_s.tvalid = 1'b0;
    $display("wrap beat data=000000bb last=1");
    total++; if (a_hash !== 32'h727703FF) begin bad++; $display("FAIL wrap_hash: got %h want 727703ff", a_hash); end
    total++; if ({a_words, a_pkts} !== {32'd1, 32'd2}) begin bad++; $display("FAIL wrap_counts: got %0d/%0d want 1/2", a_words, a_pkts); end
    total++; if (a_inpkt !== 1'b0) begin bad++; $display("FAIL wrap_inpkt_end: got %b want 0", a_inpkt); end
    tick();
  endtask

  task automatic test_reset_mid_packet();
    a_m.tready = 1'b0;
    a_s.tvalid = 1'b1; a_s.tdata = 32'h11; a_s.tlast = 1'b0;
    tick();
    a_s.tdata = 32'h22;
    tick();
    a_s.tvalid = 1'b0;
    $display("mid-packet beats 00000011 00000022 held");
    total++; if (a_s.tready !== 1'b0) begin bad++; $display("FAIL mid_full: got %b want 0", a_s.tready); end
    total++; if (a_inpkt !== 1'b1) begin bad++; $display("FAIL mid_inpkt: got %b want 1", a_inpkt); end
    ARESETN = 1'b0;
    tick();
    total++; if (a_m.tvalid !== 1'b0) begin bad++; $display("FAIL mid_mvalid: got %b want 0", a_m.tvalid); end
    total++; if ({a_s.tready, a_inpkt} !== 2'b10) begin bad++; $display("FAIL mid_rst_state: got rdy=%b inpkt=%b want 1/0", a_s.tready, a_inpkt); end
    ARESETN = 1'b1;
    a_m.tready = 1'b1;
    a_s.tvalid = 1'b1; a_s.tdata = 32'h1; a_s.tlast = 1'b1;
    tick();
    a_s.tvalid = 1'b0;
    $display("post-reset beat data=00000001 last=1");
    total++; if (a_hash !== 32'h2393B8B1) begin bad++; $display("FAIL mid_hash: got %h want 2393b8b1", a_hash); end
    total++; if ({a_words, a_pkts} !== {32'd1, 32'd1}) begin bad++; $display("FAIL mid_counts: got %0d/%0d want 1/1", a_words, a_pkts); end
    total++; if ({a_m.tvalid, a_m.tdata} !== {1'b1, 32'h1}) begin bad++; $display("FAIL mid_mout: got v=%b d=%h want 1/00000001", a_m.tvalid, a_m.tdata); end
  endtask

  initial begin
    ARESETN = 1'b0;
    a_clear = 1'b0; b_clear = 1'b0;
    a_s.tvalid = 1'b0; a_s.tdata = '0; a_s.tlast = 1'b0; a_m.tready = 1'b0;
    b_s.tvalid = 1'b0; b_s.tdata = '0; b_s.tlast = 1'b0; b_m.tready = 1'b0;
    test_reset();
    test_single_beat();
    test_back_pressure();
    test_clear_collision();
    test_word_wrap();
    test_reset_mid_packet();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
